// File: rtl/ldpc_chan_pkg.sv
// Shared definitions for the LDPC channel error injector: LFSR polynomial,
// FSM state encoding and the single-step Galois LFSR function.
package ldpc_chan_pkg;

    localparam logic [31:0] LDPC_CHAN_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INJECT   = 2'd1,
        ST_START    = 2'd2,
        ST_WAIT_DEC = 2'd3
    } state_t;

    // Right-shifting Galois step: the polynomial is folded in when the LSB shifts out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        logic [31:0] next_state;
        next_state = state >> 1;
        if (state[0]) next_state = next_state ^ LDPC_CHAN_POLY;
        return next_state;
    endfunction

endpackage

// File: rtl/ldpc_chan_lfsr_lanes.sv
// Unrolls LANES consecutive LFSR steps in one cycle; lane k sees the low 16
// bits of the state after step k+1, and the final state is handed back.
module ldpc_chan_lfsr_lanes
    import ldpc_chan_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic [31:0]             lfsr_i,
    output logic [LANES-1:0][15:0]  rnd_o,
    output logic [31:0]             lfsr_next_o
);

    logic [31:0] w_state;

    always_comb begin
        w_state = lfsr_i;
        rnd_o   = '0;
        for (int k = 0; k < LANES; k++) begin
            w_state  = lfsr_step(w_state);
            rnd_o[k] = w_state[15:0];
        end
        lfsr_next_o = w_state;
    end

endmodule

// File: rtl/ldpc_chan_err_injector.sv
// Channel emulation between LDPC encoder and decoder: captures a codeword, flips
// bits pseudo-randomly, starts the decoder and waits. Optional stats: LDPC_CHAN_STATS_EN.
module ldpc_chan_err_injector
    import ldpc_chan_pkg::*;
#(
    parameter int NN    = 208,
    parameter int LANES = 16,
    parameter int ERRW  = 8,
    parameter int CNTW  = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NN-1:0]   cw_i,
    input  logic            cw_valid_i,
    output logic            cw_ready_o,
    input  logic            enable_i,
    input  logic [15:0]     prob_i,
    input  logic [ERRW-1:0] max_err_i,
    input  logic [31:0]     seed_i,
    input  logic            seed_load_i,
    input  logic            dec_done_i,
    input  logic            dec_pass_i,
    output logic [NN-1:0]   q0_0_o,
    output logic [NN-1:0]   q0_1_o,
    output logic [NN-1:0]   err_mask_o,
    output logic            err_intro_o,
    output logic [ERRW-1:0] err_cnt_o,
    output logic            start_dec_o,
    output logic            busy_o
`ifdef LDPC_CHAN_STATS_EN
    ,
    input  logic            stats_clr_i,
    output logic [CNTW-1:0] frame_cnt_o,
    output logic [CNTW-1:0] fail_cnt_o
`endif
);

    localparam int NCHUNK = (NN + LANES - 1) / LANES;
    localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PADW   = NCHUNK * LANES;

    state_t             r_state;
    logic [31:0]        r_lfsr;
    logic [NN-1:0]      r_cw;
    logic [NN-1:0]      r_mask;
    logic [ERRW-1:0]    r_cnt;
    logic [CHW-1:0]     r_chunk;

    logic [LANES-1:0][15:0] w_rnd;
    logic [31:0]            w_lfsr_next;
    logic [LANES-1:0]       w_flips;
    logic [ERRW-1:0]        w_cnt_next;
    logic [PADW-1:0]        w_pad;
    logic [NN-1:0]          w_mask_next;

    ldpc_chan_lfsr_lanes #(.LANES(LANES)) u_lanes (
        .lfsr_i      (r_lfsr),
        .rnd_o       (w_rnd),
        .lfsr_next_o (w_lfsr_next)
    );

    // Lanes are evaluated in order so the cap sees flips from earlier lanes this cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_flips    = '0;
        w_cnt_next = r_cnt;
        for (int k = 0; k < LANES; k++) begin
            if (enable_i && ((int'(r_chunk) * LANES + k) < NN) && (w_rnd[k] < prob_i) &&
                ((max_err_i == '0) || (w_cnt_next < max_err_i))) begin
                w_flips[k] = 1'b1;
                if (w_cnt_next != '1) w_cnt_next = w_cnt_next + ERRW'(1);
            end
        end
        w_pad       = PADW'(w_flips) << (int'(r_chunk) * LANES);
        w_mask_next = r_mask | w_pad[NN-1:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            // NOTE: the wide capture and mask registers are reset because q0_* decode them directly.
            r_state <= ST_IDLE;
            r_lfsr  <= 32'h1;
            r_cw    <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_chunk <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (seed_load_i) r_lfsr <= (seed_i == 32'h0) ? 32'h1 : seed_i;
                    if (cw_valid_i) begin
                        r_cw    <= cw_i;
                        r_mask  <= '0;
                        r_cnt   <= '0;
                        r_chunk <= '0;
                        r_state <= ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    r_lfsr  <= w_lfsr_next;
                    r_mask  <= w_mask_next;
                    r_cnt   <= w_cnt_next;
                    r_chunk <= r_chunk + CHW'(1);
                    if (r_chunk == CHW'(NCHUNK - 1)) r_state <= ST_START;
                end
                ST_START: r_state <= ST_WAIT_DEC;
                ST_WAIT_DEC: begin
                    if (dec_done_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign q0_1_o      = r_cw ^ r_mask;
    assign q0_0_o      = ~(r_cw ^ r_mask);
    assign err_mask_o  = r_mask;
    assign err_intro_o = |r_mask;
    assign err_cnt_o   = r_cnt;
    assign start_dec_o = (r_state == ST_START);
    assign cw_ready_o  = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);

`ifdef LDPC_CHAN_STATS_EN
    logic [CNTW-1:0] r_frame_cnt;
    logic [CNTW-1:0] r_fail_cnt;

    // Clear wins over a same-cycle frame completion; both counters wrap.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_frame_cnt <= '0;
            r_fail_cnt  <= '0;
        end else if (stats_clr_i) begin
            r_frame_cnt <= '0;
            r_fail_cnt  <= '0;
        end else if ((r_state == ST_WAIT_DEC) && dec_done_i) begin
            r_frame_cnt <= r_frame_cnt + CNTW'(1);
            if (!dec_pass_i) r_fail_cnt <= r_fail_cnt + CNTW'(1);
        end
    end

    assign frame_cnt_o = r_frame_cnt;
    assign fail_cnt_o  = r_fail_cnt;
`else
    logic w_unused;
    assign w_unused = &{1'b0, dec_pass_i, (CNTW > 0)};
`endif

endmodule
